// File: rtl/cart_pkg.sv
// Shared types and constants for the cartridge download path.
// Bank-scheme codes match the detector's det_force_bs encoding.
package cart_pkg;

    localparam int CART_AW = 25;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        SETTLE,
        COMMIT
    } state_t;

    localparam logic [3:0] BS_NONE = 4'h0;
    localparam logic [3:0] BS_F8   = 4'h1;
    localparam logic [3:0] BS_F6   = 4'h2;
    localparam logic [3:0] BS_F4   = 4'h3;
    localparam logic [3:0] BS_E0   = 4'h4;
    localparam logic [3:0] BS_3F   = 4'h5;
    localparam logic [3:0] BS_FE   = 4'h6;
    localparam logic [3:0] BS_E7   = 4'h7;

endpackage

// File: rtl/cart_load_ctrl_dl_edge.sv
// Rise/fall detector on the qualified download signal.
// Edges are combinational against a single registered copy.
module dl_edge (
    input  logic clk_sys,
    input  logic reset,
    input  logic dl,
    output logic rise,
    output logic fall
);

    logic dl_q;

    always_ff @(posedge clk_sys) begin
        if (reset) dl_q <= 1'b0;
        else       dl_q <= dl;
    end

    assign rise = dl & ~dl_q;
    assign fall = ~dl & dl_q;

endmodule

// File: rtl/cart_load_ctrl.sv
// ROM download sequencer: HPS ioctl -> cart RAM, detector feed,
// core reset hold and commit of detected bank scheme and size.
module cart_load_ctrl
    import cart_pkg::*;
#(
    parameter logic [7:0] ROM_INDEX     = 8'h00,
    parameter int         MAX_SIZE      = 65536,
    parameter int         SETTLE_CYCLES = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic        ioctl_wait,
    output logic [24:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic        det_enable,
    output logic [12:0] det_addr,
    output logic [7:0]  det_data,
    input  logic [3:0]  det_force_bs,
    input  logic        det_sc,
    output logic [24:0] cart_size,
    output logic [3:0]  bs,
    output logic        sc,
    output logic        cart_valid,
    output logic        overflow,
    output logic        core_reset
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] SETTLE_INIT = CW'(SETTLE_CYCLES - 1);
    localparam logic [CART_AW:0] MAX_L = (CART_AW+1)'(MAX_SIZE);

    state_t state, state_nx;

    logic          dl, rise, fall;
    logic          in_range, accept, drop;
    logic [24:0]   addr_p1;
    logic          det_q, fall_pend;
    logic [CW-1:0] cnt;

    assign dl = ioctl_download & (ioctl_index == ROM_INDEX);

    dl_edge u_dl_edge (
        .clk_sys (clk_sys),
        .reset   (reset),
        .dl      (dl),
        .rise    (rise),
        .fall    (fall)
    );

    assign in_range = {1'b0, ioctl_addr} < MAX_L;
    assign accept   = (state == LOAD) & ioctl_wr & in_range;
    assign drop     = (state == LOAD) & ioctl_wr & ~in_range;
    assign addr_p1  = ioctl_addr + 25'd1;

    always_ff @(posedge clk_sys) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // A byte arriving with the fall wins; the fall is replayed after its ack.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (rise) state_nx = LOAD;
            LOAD: begin
                if (accept)    state_nx = WRITE;
                else if (fall) state_nx = SETTLE;
            end
            WRITE: begin
                if (mem_ack)
                    state_nx = (fall_pend | fall) ? SETTLE : LOAD;
            end
            SETTLE:  if (cnt == '0) state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_we     = (state == WRITE);
        ioctl_wait = (state == WRITE);
        det_enable = det_q;
    end

    assign det_addr = mem_addr[12:0];
    assign det_data = mem_din;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            mem_addr   <= '0;
            mem_din    <= '0;
            det_q      <= 1'b0;
            fall_pend  <= 1'b0;
            cnt        <= '0;
            cart_size  <= '0;
            bs         <= BS_NONE;
            sc         <= 1'b0;
            cart_valid <= 1'b0;
            overflow   <= 1'b0;
            core_reset <= 1'b1;
        end else begin
            det_q <= accept;
            if (state == IDLE && rise) begin
                cart_size  <= '0;
                overflow   <= 1'b0;
                cart_valid <= 1'b0;
                bs         <= BS_NONE;
                sc         <= 1'b0;
                core_reset <= 1'b1;
            end
            if (accept) begin
                mem_addr <= ioctl_addr;
                mem_din  <= ioctl_dout;
                if (addr_p1 > cart_size) cart_size <= addr_p1;
            end
            if (drop) overflow <= 1'b1;
            if (state == WRITE) fall_pend <= fall_pend | fall;
            else                fall_pend <= accept & fall;
            if (state != SETTLE)  cnt <= SETTLE_INIT;
            else if (cnt != '0)   cnt <= cnt - 1'b1;
            if (state == COMMIT && cart_size != '0) begin
                bs         <= det_force_bs;
                sc         <= det_sc;
                cart_valid <= 1'b1;
                core_reset <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cart_load_ctrl.sv
// Randomized bench for cart_load_ctrl against a queue-based model
// of accepted bytes, cart size, overflow and commit results.
module tb_cart_load_ctrl;

    localparam int MAX    = 4096;
    localparam int SETTLE = 4;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [7:0]  ioctl_index = '0;
    logic        ioctl_wait;
    logic [24:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_we;
    logic        mem_ack = 1'b0;
    logic        det_enable;
    logic [12:0] det_addr;
    logic [7:0]  det_data;
    logic [3:0]  det_force_bs = '0;
    logic        det_sc = 1'b0;
    logic [24:0] cart_size;
    logic [3:0]  bs;
    logic        sc, cart_valid, overflow, core_reset;

    int n_cmp = 0;
    int n_bad = 0;

    cart_load_ctrl #(
        .ROM_INDEX     (8'h00),
        .MAX_SIZE      (MAX),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .ioctl_wait     (ioctl_wait),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_we         (mem_we),
        .mem_ack        (mem_ack),
        .det_enable     (det_enable),
        .det_addr       (det_addr),
        .det_data       (det_data),
        .det_force_bs   (det_force_bs),
        .det_sc         (det_sc),
        .cart_size      (cart_size),
        .bs             (bs),
        .sc             (sc),
        .cart_valid     (cart_valid),
        .overflow       (overflow),
        .core_reset     (core_reset)
    );

    always #5 clk_sys = ~clk_sys;

    // cart RAM responder: ack arrives ack_delay cycles after mem_we rises
    int ack_delay = 2;
    int ack_cnt = 0;
    always @(posedge clk_sys) begin
        if (reset || !mem_we || mem_ack) begin
            mem_ack <= 1'b0;
            ack_cnt <= 0;
        end else if (ack_cnt + 1 >= ack_delay) begin
            mem_ack <= 1'b1;
            ack_cnt <= 0;
        end else begin
            ack_cnt <= ack_cnt + 1;
        end
    end

    // observation log, sampled on the falling edge
    int          cyc = 0;
    logic        we_prev = 1'b0;
    logic        valid_prev = 1'b0;
    logic [24:0] obs_a[$];
    logic [7:0]  obs_d[$];
    logic [12:0] det_a[$];
    logic [7:0]  det_d[$];
    int          det_bad = 0;
    int          wait_run = 0;
    int          last_wait_run = 0;
    int          ack_cyc = 0;
    int          valid_cyc = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (mem_we && !we_prev) begin
            obs_a.push_back(mem_addr);
            obs_d.push_back(mem_din);
        end
        if (det_enable) begin
            det_a.push_back(det_addr);
            det_d.push_back(det_data);
            if (!(mem_we && !we_prev)) det_bad <= det_bad + 1;
        end
        if (ioctl_wait) begin
            wait_run <= wait_run + 1;
        end else if (wait_run != 0) begin
            last_wait_run <= wait_run;
            wait_run <= 0;
        end
        if (mem_ack) ack_cyc <= cyc;
        if (cart_valid && !valid_prev) valid_cyc <= cyc;
        we_prev    <= mem_we;
        valid_prev <= cart_valid;
    end

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: cycles=%0d required below 95000", cyc);
        $fatal(1, "watchdog");
    end

    // reference model: bytes the cart should receive and the resulting commit
    logic [24:0] exp_a[$];
    logic [7:0]  exp_d[$];
    int          m_size = 0;
    bit          m_ovf = 1'b0;

    task automatic model_start();
        exp_a.delete();
        exp_d.delete();
        m_size = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_byte(input logic [24:0] a, input logic [7:0] d);
        if (int'(a) < MAX) begin
            exp_a.push_back(a);
            exp_d.push_back(d);
            if (int'(a) + 1 > m_size) m_size = int'(a) + 1;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    function automatic int write_errs(input int ob, input int db);
        int e = 0;
        if (obs_a.size() - ob != exp_a.size()) e++;
        if (det_a.size() - db != exp_a.size()) e++;
        for (int i = 0; i < exp_a.size(); i++) begin
            if (ob + i < obs_a.size()) begin
                if (obs_a[ob+i] !== exp_a[i]) e++;
                if (obs_d[ob+i] !== exp_d[i]) e++;
            end
            if (db + i < det_a.size()) begin
                if (det_a[db+i] !== exp_a[i][12:0]) e++;
                if (det_d[db+i] !== exp_d[i]) e++;
            end
        end
        return e;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d,
                             input bit drop_dl);
        int g = 0;
        while (ioctl_wait && g < 200) begin
            tick();
            g++;
        end
        n_cmp++;
        if (ioctl_wait !== 1'b0) begin
            n_bad++;
            $display("FAIL wait_timeout: ioctl_wait=%b required 0", ioctl_wait);
        end
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        if (drop_dl) ioctl_download = 1'b0;
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic start_load(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick(2);
    endtask

    task automatic end_load();
        ioctl_download = 1'b0;
        tick(SETTLE + 30);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        n_cmp++;
        if (core_reset !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_core_reset: got %b want 1", core_reset);
        end
        n_cmp++;
        if ({mem_we, ioctl_wait, det_enable, cart_valid, overflow} !== 5'b0) begin
            n_bad++;
            $display("FAIL rst_flags: got %b want 00000",
                     {mem_we, ioctl_wait, det_enable, cart_valid, overflow});
        end
        n_cmp++;
        if ({cart_size, bs, sc, mem_addr, mem_din} !== '0) begin
            n_bad++;
            $display("FAIL rst_data: size=%0h bs=%0h sc=%b addr=%0h din=%0h want 0",
                     cart_size, bs, sc, mem_addr, mem_din);
        end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_4k_load();
        int ob = obs_a.size();
        int db = det_a.size();
        int dbad = det_bad;
        int e;
        logic [7:0] d;
        ack_delay    = 2;
        det_force_bs = 4'h0;
        det_sc       = 1'b0;
        model_start();
        start_load(8'h00);
        for (int i = 0; i < 4096; i++) begin
            d = 8'($urandom);
            send_byte(25'(i), d, 1'b0);
            model_byte(25'(i), d);
        end
        end_load();
        e = write_errs(ob, db);
        n_cmp++;
        if (e != 0) begin
            n_bad++;
            $display("FAIL t4k_writes: %0d bad entries want 0", e);
        end
        n_cmp++;
        if (cart_size !== 25'(m_size)) begin
            n_bad++;
            $display("FAIL t4k_size: got %0d want %0d", cart_size, m_size);
        end
        n_cmp++;
        if ({cart_valid, core_reset, overflow, bs} !== {1'b1, 1'b0, 1'b0, 4'h0}) begin
            n_bad++;
            $display("FAIL t4k_commit: valid=%b core_reset=%b ovf=%b bs=%0h want 1 0 0 0",
                     cart_valid, core_reset, overflow, bs);
        end
        n_cmp++;
        if (valid_cyc - ack_cyc != SETTLE + 2) begin
            n_bad++;
            $display("FAIL t4k_latency: got %0d want %0d",
                     valid_cyc - ack_cyc, SETTLE + 2);
        end
        n_cmp++;
        if (det_bad != dbad) begin
            n_bad++;
            $display("FAIL t4k_det_align: got %0d misaligned want 0", det_bad - dbad);
        end
    endtask

    task automatic test_wait_stall();
        int ob = obs_a.size();
        int db = det_a.size();
        int e;
        logic [7:0] d;
        logic [3:0] fbs;
        fbs          = 4'($urandom_range(1, 15));
        det_force_bs = fbs;
        det_sc       = 1'b1;
        ack_delay    = 10;
        model_start();
        start_load(8'h00);
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            send_byte(25'(i), d, 1'b0);
            model_byte(25'(i), d);
            if (i == 0) begin
                tick(3);
                n_cmp++;
                if (ioctl_wait !== 1'b1) begin
                    n_bad++;
                    $display("FAIL stall_wait_high: got %b want 1", ioctl_wait);
                end
                ioctl_addr = 25'h7ff;
                ioctl_dout = 8'hAA;
                ioctl_wr   = 1'b1;
                tick();
                ioctl_wr = 1'b0;
            end
        end
        end_load();
        // wait covers the ack_delay stall cycles plus the cycle the ack is seen
        n_cmp++;
        if (last_wait_run != ack_delay + 1) begin
            n_bad++;
            $display("FAIL stall_wait_len: got %0d want %0d",
                     last_wait_run, ack_delay + 1);
        end
        e = write_errs(ob, db);
        n_cmp++;
        if (e != 0) begin
            n_bad++;
            $display("FAIL stall_writes: %0d bad entries want 0", e);
        end
        n_cmp++;
        if ({cart_size, bs, sc, cart_valid} !== {25'(m_size), fbs, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL stall_commit: size=%0d bs=%0h sc=%b valid=%b want %0d %0h 1 1",
                     cart_size, bs, sc, cart_valid, m_size, fbs);
        end
    endtask

    task automatic test_overflow();
        int ob = obs_a.size();
        int db = det_a.size();
        int e;
        logic [7:0] d;
        ack_delay    = 1;
        det_force_bs = 4'hA;
        det_sc       = 1'b1;
        model_start();
        start_load(8'h00);
        for (int i = 0; i < 8192; i++) begin
            d = 8'($urandom);
            send_byte(25'(i), d, 1'b0);
            model_byte(25'(i), d);
        end
        end_load();
        e = write_errs(ob, db);
        n_cmp++;
        if (e != 0 || obs_a.size() - ob != 4096) begin
            n_bad++;
            $display("FAIL ovf_writes: %0d bad, %0d writes want 4096",
                     e, obs_a.size() - ob);
        end
        n_cmp++;
        if ({overflow, cart_size, cart_valid} !== {m_ovf, 25'(m_size), 1'b1}) begin
            n_bad++;
            $display("FAIL ovf_state: ovf=%b size=%0d valid=%b want %b %0d 1",
                     overflow, cart_size, cart_valid, m_ovf, m_size);
        end
    endtask

    task automatic test_bad_index();
        int ob = obs_a.size();
        int db = det_a.size();
        start_load(8'h01);
        for (int i = 0; i < 20; i++) send_byte(25'(i), 8'($urandom), 1'b0);
        end_load();
        ioctl_index = 8'h00;
        n_cmp++;
        if (obs_a.size() != ob || det_a.size() != db) begin
            n_bad++;
            $display("FAIL idx_activity: writes=%0d det=%0d want 0 0",
                     obs_a.size() - ob, det_a.size() - db);
        end
        n_cmp++;
        if ({core_reset, cart_valid, cart_size} !== {1'b0, 1'b1, 25'(m_size)}) begin
            n_bad++;
            $display("FAIL idx_idle: core_reset=%b valid=%b size=%0d want 0 1 %0d",
                     core_reset, cart_valid, cart_size, m_size);
        end
    endtask

    task automatic test_empty();
        model_start();
        start_load(8'h00);
        n_cmp++;
        if ({cart_valid, bs, sc, cart_size, core_reset} !== {1'b0, 4'h0, 1'b0, 25'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL empty_clear: valid=%b bs=%0h sc=%b size=%0d core_reset=%b want 0 0 0 0 1",
                     cart_valid, bs, sc, cart_size, core_reset);
        end
        end_load();
        n_cmp++;
        if ({cart_valid, core_reset} !== 2'b01) begin
            n_bad++;
            $display("FAIL empty_commit: valid=%b core_reset=%b want 0 1",
                     cart_valid, core_reset);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            int ob = obs_a.size();
            int db = det_a.size();
            int n;
            int e;
            logic [24:0] a;
            logic [7:0]  d;
            logic [3:0]  fbs;
            logic        fsc;
            bit          ok;
            fbs          = 4'($urandom);
            fsc          = 1'($urandom);
            det_force_bs = fbs;
            det_sc       = fsc;
            ack_delay    = $urandom_range(1, 4);
            n            = $urandom_range(20, 60);
            model_start();
            start_load(8'h00);
            for (int i = 0; i < n; i++) begin
                a = 25'($urandom_range(0, MAX + 511));
                d = 8'($urandom);
                send_byte(a, d, i == n - 1);
                model_byte(a, d);
            end
            end_load();
            e = write_errs(ob, db);
            n_cmp++;
            if (e != 0) begin
                n_bad++;
                $display("FAIL rnd%0d_writes: %0d bad entries want 0", it, e);
            end
            n_cmp++;
            if ({cart_size, overflow} !== {25'(m_size), m_ovf}) begin
                n_bad++;
                $display("FAIL rnd%0d_size: size=%0d ovf=%b want %0d %b",
                         it, cart_size, overflow, m_size, m_ovf);
            end
            ok = (m_size != 0);
            n_cmp++;
            if ({cart_valid, core_reset, bs, sc} !==
                {ok, !ok, ok ? fbs : 4'h0, ok ? fsc : 1'b0}) begin
                n_bad++;
                $display("FAIL rnd%0d_commit: valid=%b core_reset=%b bs=%0h sc=%b want %b %b %0h %b",
                         it, cart_valid, core_reset, bs, sc, ok, !ok,
                         ok ? fbs : 4'h0, ok ? fsc : 1'b0);
            end
        end
    endtask

    task automatic test_reset_in_write();
        int ob;
        int db;
        int e;
        logic [7:0] d;
        ack_delay = 10;
        start_load(8'h00);
        send_byte(25'h10, 8'h5A, 1'b0);
        tick(2);
        reset          = 1'b1;
        ioctl_download = 1'b0;
        tick();
        n_cmp++;
        if ({mem_we, ioctl_wait, core_reset, cart_valid} !== 4'b0010) begin
            n_bad++;
            $display("FAIL rstw_abort: we=%b wait=%b core_reset=%b valid=%b want 0 0 1 0",
                     mem_we, ioctl_wait, core_reset, cart_valid);
        end
        reset = 1'b0;
        tick(2);
        ob           = obs_a.size();
        db           = det_a.size();
        ack_delay    = 3;
        det_force_bs = 4'h3;
        det_sc       = 1'b0;
        model_start();
        start_load(8'h00);
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            send_byte(25'(i), d, 1'b0);
            model_byte(25'(i), d);
        end
        end_load();
        e = write_errs(ob, db);
        n_cmp++;
        if (e != 0) begin
            n_bad++;
            $display("FAIL rstw_writes: %0d bad entries want 0", e);
        end
        n_cmp++;
        if ({cart_size, cart_valid, core_reset, bs} !== {25'd16, 1'b1, 1'b0, 4'h3}) begin
            n_bad++;
            $display("FAIL rstw_reload: size=%0d valid=%b core_reset=%b bs=%0h want 16 1 0 3",
                     cart_size, cart_valid, core_reset, bs);
        end
    endtask

    initial begin
        test_reset();
        test_4k_load();
        test_wait_stall();
        test_overflow();
        test_bad_index();
        test_empty();
        test_random();
        test_reset_in_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
